// File: rtl/idma_axi_mem_sub.sv
// AXI4 subordinate backed by a byte-lane register-array memory; mirrors the iDMA
// backend manager ports. Illegal beats answer SLVERR; one read and one write in flight.
module idma_axi_mem_sub #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned AxiIdWidth  = 1,
    parameter int unsigned NumWords    = 256,
    parameter int unsigned BaseAddr    = 0,
    parameter int unsigned StrbWidth   = DataWidth / 8,
    parameter int unsigned OffsetWidth = $clog2(StrbWidth)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AxiIdWidth-1:0] axi_aw_id_i,
    input  logic [AddrWidth-1:0]  axi_aw_addr_i,
    input  logic [7:0]            axi_aw_len_i,
    input  logic [2:0]            axi_aw_size_i,
    input  logic [1:0]            axi_aw_burst_i,
    input  logic                  axi_aw_valid_i,
    output logic                  axi_aw_ready_o,
    input  logic [DataWidth-1:0]  axi_w_data_i,
    input  logic [StrbWidth-1:0]  axi_w_strb_i,
    input  logic                  axi_w_last_i,
    input  logic                  axi_w_valid_i,
    output logic                  axi_w_ready_o,
    output logic [AxiIdWidth-1:0] axi_b_id_o,
    output logic [1:0]            axi_b_resp_o,
    output logic                  axi_b_valid_o,
    input  logic                  axi_b_ready_i,
    input  logic [AxiIdWidth-1:0] axi_ar_id_i,
    input  logic [AddrWidth-1:0]  axi_ar_addr_i,
    input  logic [7:0]            axi_ar_len_i,
    input  logic [2:0]            axi_ar_size_i,
    input  logic [1:0]            axi_ar_burst_i,
    input  logic                  axi_ar_valid_i,
    output logic                  axi_ar_ready_o,
    output logic [AxiIdWidth-1:0] axi_r_id_o,
    output logic [DataWidth-1:0]  axi_r_data_o,
    output logic [1:0]            axi_r_resp_o,
    output logic                  axi_r_last_o,
    output logic                  axi_r_valid_o,
    input  logic                  axi_r_ready_i
);

    localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth:0] MemLo   = (AddrWidth+1)'(BaseAddr);
    localparam logic [AddrWidth:0] MemSpan = (AddrWidth+1)'(NumWords * StrbWidth);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;

    // An address below the base wraps the offset past the span, so one compare covers both ends.
    function automatic logic beat_err(input logic [AddrWidth-1:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst);
        logic [AddrWidth:0] off;
        off = {1'b0, addr} - MemLo;
        return (off >= MemSpan) || (size > 3'(OffsetWidth)) || burst[1];
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [2:0] size, input logic [1:0] burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(1) << size;
        if (burst == BurstFixed) return addr;
        return (addr & ~(step - AddrWidth'(1))) + step;
    endfunction

    function automatic logic [IdxWidth-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] off;
        off = addr - AddrWidth'(BaseAddr);
        return IdxWidth'(off >> OffsetWidth);
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e              w_state_reg, w_state_next;
    logic [AxiIdWidth-1:0] w_id_reg, w_id_next;
    logic [AddrWidth-1:0]  w_addr_reg, w_addr_next;
    logic [7:0]            w_len_reg, w_len_next, w_beat_reg, w_beat_next;
    logic [2:0]            w_size_reg, w_size_next;
    logic [1:0]            w_burst_reg, w_burst_next;
    logic                  w_err_reg, w_err_next;
    logic                  aw_fire, w_fire, w_final, w_beat_err;
    logic [IdxWidth-1:0]   w_idx;

    r_state_e              r_state_reg, r_state_next;
    logic [AxiIdWidth-1:0] r_id_reg, r_id_next;
    logic [AddrWidth-1:0]  r_addr_reg, r_addr_next, rd_addr;
    logic [7:0]            r_len_reg, r_len_next, r_beat_reg, r_beat_next;
    logic [2:0]            r_size_reg, r_size_next, rd_size;
    logic [1:0]            r_burst_reg, r_burst_next, rd_burst;
    logic [1:0]            r_resp_reg, r_resp_next;
    logic                  r_last_reg, r_last_next;
    logic                  ar_fire, r_fire, r_load, rd_err;
    logic [IdxWidth-1:0]   rd_idx;

    assign axi_aw_ready_o = !rst_i && (w_state_reg == W_IDLE);
    assign axi_w_ready_o  = !rst_i && (w_state_reg == W_DATA);
    assign axi_b_valid_o  = !rst_i && (w_state_reg == W_RESP);
    assign axi_b_id_o     = axi_b_valid_o ? w_id_reg : '0;
    assign axi_b_resp_o   = axi_b_valid_o ? (w_err_reg ? RespSlverr : RespOkay) : 2'b00;

    assign aw_fire    = axi_aw_valid_i && axi_aw_ready_o;
    assign w_fire     = axi_w_valid_i && axi_w_ready_o;
    assign w_final    = (w_beat_reg == w_len_reg);
    assign w_beat_err = beat_err(w_addr_reg, w_size_reg, w_burst_reg);
    assign w_idx      = word_idx(w_addr_reg);

    always_comb begin
        w_state_next = w_state_reg;
        w_id_next    = w_id_reg;
        w_addr_next  = w_addr_reg;
        w_len_next   = w_len_reg;
        w_size_next  = w_size_reg;
        w_burst_next = w_burst_reg;
        w_beat_next  = w_beat_reg;
        w_err_next   = w_err_reg;
        case (w_state_reg)
            W_IDLE: if (aw_fire) begin
                w_id_next    = axi_aw_id_i;
                w_addr_next  = axi_aw_addr_i;
                w_len_next   = axi_aw_len_i;
                w_size_next  = axi_aw_size_i;
                w_burst_next = axi_aw_burst_i;
                w_beat_next  = 8'd0;
                w_err_next   = 1'b0;
                w_state_next = W_DATA;
            end
            W_DATA: if (w_fire) begin
                // The beat counter ends the burst; a misplaced w_last only poisons the response.
                if (w_beat_err || (axi_w_last_i != w_final)) w_err_next = 1'b1;
                if (w_final) begin
                    w_state_next = W_RESP;
                end else begin
                    w_beat_next = w_beat_reg + 8'd1;
                    w_addr_next = next_addr(w_addr_reg, w_size_reg, w_burst_reg);
                end
            end
            W_RESP: if (axi_b_ready_i) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= '0;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_id_reg    <= w_id_next;
            w_addr_reg  <= w_addr_next;
            w_len_reg   <= w_len_next;
            w_size_reg  <= w_size_next;
            w_burst_reg <= w_burst_next;
            w_beat_reg  <= w_beat_next;
            w_err_reg   <= w_err_next;
        end
    end

    assign axi_ar_ready_o = !rst_i && (r_state_reg == R_IDLE);
    assign axi_r_valid_o  = !rst_i && (r_state_reg == R_DATA);
    assign axi_r_id_o     = axi_r_valid_o ? r_id_reg : '0;
    assign axi_r_resp_o   = axi_r_valid_o ? r_resp_reg : 2'b00;
    assign axi_r_last_o   = axi_r_valid_o && r_last_reg;
    assign ar_fire        = axi_ar_valid_i && axi_ar_ready_o;
    assign r_fire         = axi_r_valid_o && axi_r_ready_i;
    assign rd_idx         = word_idx(rd_addr);

    // rd_addr is the beat being registered: the AR address, or the next beat on a handshake.
    always_comb begin
        r_state_next = r_state_reg;
        r_id_next    = r_id_reg;
        r_addr_next  = r_addr_reg;
        r_len_next   = r_len_reg;
        r_size_next  = r_size_reg;
        r_burst_next = r_burst_reg;
        r_beat_next  = r_beat_reg;
        r_last_next  = r_last_reg;
        r_resp_next  = r_resp_reg;
        r_load       = 1'b0;
        rd_addr      = r_addr_reg;
        rd_size      = r_size_reg;
        rd_burst     = r_burst_reg;
        case (r_state_reg)
            R_IDLE: if (ar_fire) begin
                r_id_next    = axi_ar_id_i;
                r_addr_next  = axi_ar_addr_i;
                r_len_next   = axi_ar_len_i;
                r_size_next  = axi_ar_size_i;
                r_burst_next = axi_ar_burst_i;
                r_beat_next  = 8'd0;
                r_last_next  = (axi_ar_len_i == 8'd0);
                rd_addr      = axi_ar_addr_i;
                rd_size      = axi_ar_size_i;
                rd_burst     = axi_ar_burst_i;
                r_load       = 1'b1;
                r_state_next = R_DATA;
            end
            R_DATA: if (r_fire) begin
                if (r_last_reg) begin
                    r_state_next = R_IDLE;
                end else begin
                    rd_addr     = next_addr(r_addr_reg, r_size_reg, r_burst_reg);
                    r_addr_next = rd_addr;
                    r_beat_next = r_beat_reg + 8'd1;
                    r_last_next = (r_beat_next == r_len_reg);
                    r_load      = 1'b1;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
        rd_err = beat_err(rd_addr, rd_size, rd_burst);
        if (r_load) r_resp_next = rd_err ? RespSlverr : RespOkay;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            r_beat_reg  <= '0;
            r_last_reg  <= 1'b0;
            r_resp_reg  <= 2'b00;
        end else begin
            r_state_reg <= r_state_next;
            r_id_reg    <= r_id_next;
            r_addr_reg  <= r_addr_next;
            r_len_reg   <= r_len_next;
            r_size_reg  <= r_size_next;
            r_burst_reg <= r_burst_next;
            r_beat_reg  <= r_beat_next;
            r_last_reg  <= r_last_next;
            r_resp_reg  <= r_resp_next;
        end
    end

    // One memory per byte lane so strobed writes map onto plain RAM write ports.
    genvar gi;
    for (gi = 0; gi < StrbWidth; gi++) begin : gen_lane
        logic [7:0] mem_array [NumWords];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk_i) begin
            if (w_fire && !w_beat_err && axi_w_strb_i[gi]) mem_array[w_idx] <= axi_w_data_i[gi*8 +: 8];
        end

        always_ff @(posedge clk_i) begin
            if (r_load) rd_byte_reg <= rd_err ? 8'h00 : mem_array[rd_idx];
        end

        assign axi_r_data_o[gi*8 +: 8] = rst_i ? 8'h00 : rd_byte_reg;
    end

endmodule

// File: tb/tb_idma_axi_mem_sub.sv
// Randomized and directed bench for idma_axi_mem_sub against a byte-array memory model
// that applies the address, burst and error rules beat by beat.
module tb_idma_axi_mem_sub;

    localparam int NW   = 256;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  aw_id = '0, ar_id = '0;
    logic [31:0] aw_addr = '0, ar_addr = '0;
    logic [7:0]  aw_len = '0, ar_len = '0;
    logic [2:0]  aw_size = '0, ar_size = '0;
    logic [1:0]  aw_burst = '0, ar_burst = '0;
    logic        aw_valid = 1'b0, ar_valid = 1'b0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 1'b0, w_valid = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [0:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;

    idma_axi_mem_sub #(.DataWidth(32), .AddrWidth(32), .AxiIdWidth(1), .NumWords(NW), .BaseAddr(BASE)) dut (
        .clk_i(clk), .rst_i(rst),
        .axi_aw_id_i(aw_id), .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
        .axi_aw_burst_i(aw_burst), .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready),
        .axi_w_data_i(w_data), .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready),
        .axi_b_id_o(b_id), .axi_b_resp_o(b_resp), .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready),
        .axi_ar_id_i(ar_id), .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
        .axi_ar_burst_i(ar_burst), .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready),
        .axi_r_id_o(r_id), .axi_r_data_o(r_data), .axi_r_resp_o(r_resp), .axi_r_last_o(r_last),
        .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready)
    );

    always #5 clk = ~clk;

    logic [7:0]  model_mem [NW*4];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] rd_data_q [$];
    logic [1:0]  rd_resp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(longint addr, int size, int burst);
        return (addr < BASE) || (addr >= BASE + NW*4) || (size > 2) || (burst >= 2);
    endfunction

    function automatic longint m_next(longint addr, int size, int burst);
        longint step = longint'(1) << size;
        if (burst == 0) return addr;
        return (addr / step) * step + step;
    endfunction

    function automatic logic [31:0] m_word(longint addr);
        int w = int'((addr - BASE) / 4);
        return {model_mem[w*4+3], model_mem[w*4+2], model_mem[w*4+1], model_mem[w*4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [0:0] id, input logic [31:0] addr, input int len, input int size, input int burst);
        int guard = 0;
        bit hs;
        aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst); aw_valid = 1'b1;
        do begin hs = aw_ready; tick(); guard++; end while (!hs && guard < 50);
        aw_valid = 1'b0;
        check("aw_handshake", 64'(hs), 1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int guard = 0;
        bit hs;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        do begin hs = w_ready; tick(); guard++; end while (!hs && guard < 50);
        w_valid = 1'b0; w_last = 1'b0;
        check("w_handshake", 64'(hs), 1);
    endtask

    // Updates the model first, then drives the burst and checks B against the model's verdict.
    task automatic axi_write(input logic [0:0] id, input logic [31:0] addr, input int len, input int size,
                             input int burst, input int bad_last, input int b_stall, output logic [1:0] resp);
        longint a = addr;
        bit err = 0;
        int guard = 0;
        bit hs;
        logic [1:0] exp_resp;
        for (int b = 0; b <= len; b++) begin
            if (m_err(a, size, burst)) err = 1;
            else for (int l = 0; l < 4; l++)
                if (wstb[b][l]) model_mem[int'((a - BASE) / 4) * 4 + l] = wdat[b][8*l +: 8];
            if (b == bad_last) err = 1;
            a = m_next(a, size, burst);
        end
        exp_resp = err ? 2'b10 : 2'b00;
        send_aw(id, addr, len, size, burst);
        check("w_ready_latency", 64'(w_ready), 1);
        for (int b = 0; b <= len; b++) send_w(wdat[b], wstb[b], (b == len) != (b == bad_last));
        check("b_valid_latency", 64'(b_valid), 1);
        check("b_resp", 64'(b_resp), 64'(exp_resp));
        check("b_id", 64'(b_id), 64'(id));
        for (int s = 0; s < b_stall; s++) begin
            tick();
            check("b_resp_stall", 64'(b_resp), 64'(exp_resp));
            check("aw_ready_stall", 64'(aw_ready), 0);
        end
        resp = b_resp;
        b_ready = 1'b1;
        do begin hs = b_valid; tick(); guard++; end while (!hs && guard < 50);
        b_ready = 1'b0;
        check("b_handshake", 64'(hs), 1);
        check("aw_ready_after_b", 64'(aw_ready), 1);
        $display("WR id=%0d addr=0x%0h len=%0d size=%0d burst=%0d resp=%0d", id, addr, len, size, burst, resp);
    endtask

    task automatic axi_read(input logic [0:0] id, input logic [31:0] addr, input int len, input int size,
                            input int burst, input int fix_stall);
        longint a = addr;
        int guard = 0;
        bit hs;
        bit e;
        int stall;
        logic [31:0] exp_data;
        rd_data_q.delete();
        rd_resp_q.delete();
        ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst); ar_valid = 1'b1;
        do begin hs = ar_ready; tick(); guard++; end while (!hs && guard < 50);
        ar_valid = 1'b0;
        check("ar_handshake", 64'(hs), 1);
        check("r_valid_latency", 64'(r_valid), 1);
        for (int b = 0; b <= len; b++) begin
            e = m_err(a, size, burst);
            exp_data = e ? 32'h0 : m_word(a);
            stall = (fix_stall >= 0 && b == 1) ? fix_stall : int'($urandom_range(0, 2));
            for (int s = 0; s < stall; s++) begin
                check("r_data_stall", 64'(r_data), 64'(exp_data));
                check("r_last_stall", 64'(r_last), 64'(b == len));
                tick();
            end
            r_ready = 1'b1;
            check("r_valid", 64'(r_valid), 1);
            check("r_data", 64'(r_data), 64'(exp_data));
            check("r_resp", 64'(r_resp), e ? 2 : 0);
            check("r_last", 64'(r_last), 64'(b == len));
            check("r_id", 64'(r_id), 64'(id));
            rd_data_q.push_back(r_data);
            rd_resp_q.push_back(r_resp);
            tick();
            r_ready = 1'b0;
            a = m_next(a, size, burst);
        end
        check("r_valid_after_last", 64'(r_valid), 0);
        $display("RD id=%0d addr=0x%0h len=%0d size=%0d burst=%0d first=0x%0h", id, addr, len, size, burst, rd_data_q[0]);
    endtask

    initial begin
        logic [1:0] resp;
        int len, size, burst, bad;
        logic [31:0] addr;

        repeat (3) tick();
        check("rst_aw_ready", 64'(aw_ready), 0);
        check("rst_ar_ready", 64'(ar_ready), 0);
        check("rst_valids", 64'({w_ready, b_valid, r_valid, r_last}), 0);
        check("rst_r_data", 64'(r_data), 0);
        rst = 1'b0;
        #1;
        check("post_rst_aw_ready", 64'(aw_ready), 1);
        check("post_rst_ar_ready", 64'(ar_ready), 1);

        for (int b = 0; b < 256; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
        axi_write(0, 32'h0, 255, 2, 1, -1, 0, resp);

        for (int b = 0; b < 4; b++) wdat[b] = 32'hA0 + b;
        axi_write(1, 32'h10, 3, 2, 1, -1, 0, resp);
        check("t1_b_resp", 64'(resp), 0);
        axi_read(1, 32'h10, 3, 2, 1, -1);
        for (int b = 0; b < 4; b++) check("t1_r_data", 64'(rd_data_q[b]), 64'(32'hA0 + b));

        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        axi_write(0, 32'h0, 0, 2, 1, -1, 0, resp);
        wdat[0] = 32'h1234_5678; wstb[0] = 4'b0101;
        axi_write(0, 32'h0, 0, 2, 1, -1, 0, resp);
        axi_read(0, 32'h0, 0, 2, 1, -1);
        check("strobe_merge", 64'(rd_data_q[0]), 64'(32'hFF34_FF78));

        axi_read(0, 32'(BASE + NW*4 - 4), 1, 2, 1, -1);
        check("oor_beat0_resp", 64'(rd_resp_q[0]), 0);
        check("oor_beat1_resp", 64'(rd_resp_q[1]), 2);
        check("oor_beat1_data", 64'(rd_data_q[1]), 0);
        for (int b = 0; b < 2; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
        axi_write(0, 32'h20, 1, 2, 2, -1, 0, resp);
        check("wrap_b_resp", 64'(resp), 2);
        axi_read(0, 32'h20, 1, 2, 1, -1);

        for (int b = 0; b < 4; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
        axi_write(1, 32'h40, 3, 2, 1, -1, 3, resp);
        axi_read(1, 32'h40, 3, 2, 1, 5);

        for (int b = 0; b < 4; b++) begin wdat[b] = 32'hC0DE_0000 + b; wstb[b] = 4'hF; end
        axi_write(0, 32'h8, 3, 2, 0, -1, 0, resp);
        axi_read(0, 32'h8, 0, 2, 1, -1);
        check("fixed_last_wins", 64'(rd_data_q[0]), 64'(32'hC0DE_0003));

        for (int b = 0; b < 6; b++) begin
            wstb[b] = 4'(1 << ((2 + b) % 4));
            wdat[b] = {4{8'(8'h50 + b)}};
        end
        axi_write(0, 32'h2, 5, 0, 1, -1, 0, resp);
        axi_read(0, 32'h0, 1, 2, 1, -1);
        check("narrow_word0_hi", 64'(rd_data_q[0][31:16]), 64'(16'h5150));
        check("narrow_word1", 64'(rd_data_q[1]), 64'(32'h5554_5352));

        // Reset after two of four beats: only those two may land in memory.
        for (int b = 0; b < 4; b++) wdat[b] = $urandom;
        send_aw(1, 32'h80, 3, 2, 1);
        for (int b = 0; b < 2; b++) begin
            send_w(wdat[b], 4'hF, 1'b0);
            for (int l = 0; l < 4; l++) model_mem[(32 + b) * 4 + l] = wdat[b][8*l +: 8];
        end
        w_data = wdat[2]; w_strb = 4'hF; w_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid}), 0);
        tick();
        check("midrst_outputs_hold", 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid}), 0);
        tick();
        rst = 1'b0; w_valid = 1'b0;
        #1;
        check("midrst_aw_ready", 64'(aw_ready), 1);
        for (int s = 0; s < 3; s++) begin tick(); check("midrst_no_b", 64'(b_valid), 0); end
        axi_read(1, 32'h80, 3, 2, 1, -1);

        for (int t = 0; t < 40; t++) begin
            addr  = $urandom_range(0, 32'h420);
            len   = $urandom_range(0, 7);
            size  = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 2));
            burst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
            bad   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            for (int b = 0; b <= len; b++) begin wdat[b] = $urandom; wstb[b] = 4'($urandom); end
            axi_write(1'($urandom), addr, len, size, burst, bad, $urandom_range(0, 2), resp);
            axi_read(1'($urandom), addr, len, size, burst, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
